// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the unified memory.
// The arbiter connects through the master modport (it masters the memory side);
// the surrounding pipeline/memory environment uses the slave modport.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // instruction port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              bus_err;
  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // hazard unit
  logic              stall_if;
  logic              stall_mem;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the IF (instruction)
// and MEM (data) pipeline stages. One access in flight at a time, data port has
// priority with a streak cap, and a per-access timeout aborts hung accesses.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.master bus
);

  localparam int STRK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_D_STREAK);
  localparam logic [STRK_W-1:0] STRK_ONE  = STRK_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              bus_err_q, bus_err_d;

  // A port pulsing valid this cycle is not eligible, which prevents a second
  // grant for a request the pipeline has not yet had the chance to drop.
  logic elig_d, elig_i;
  assign elig_d = bus.d_req  & ~d_valid_q;
  assign elig_i = bus.if_req & ~if_valid_q;

  // Next-state, grant selection, memory-side latching and completion pulses
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (elig_d && !(elig_i && (streak_q == STRK_MAX))) begin
          // Data wins unless the instruction port has already been passed over
          // MAX_D_STREAK times in a row.
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          streak_d    = elig_i ? (streak_q + STRK_ONE) : '0;
        end else if (elig_i) begin
          state_d    = GNT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          streak_d   = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end

      GNT_D, GNT_I: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tcnt_d    = '0;
          if (state_q == GNT_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = bus.mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          // Hung memory: complete the access towards the requester with an error.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tcnt_d    = '0;
          bus_err_d = 1'b1;
          if (state_q == GNT_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req  & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios plus a randomized
// two-port run checked against a memory/arbitration reference model.
module tb_unified_mem_arbiter;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // memory contents seen by the responder, and the bench's own view of data stores
  logic [63:0] mem     [logic [63:0]];
  logic [63:0] dshadow [logic [63:0]];
  bit hang     = 1'b0;
  bit rand_lat = 1'b0;
  int lat      = 2;
  int rcnt     = 0;
  int cur_lat  = 1;

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {~a[31:0], a[31:0]} ^ 64'h5a5a_0000_0000_c3c3;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  // memory responder: answers after a programmable number of mem_req cycles
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      if (bus.mem_req && !hang) begin
        if (rcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
        rcnt++;
        if (rcnt >= cur_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic fetch(input logic [63:0] a, output logic [63:0] rd, output bit err, output bit ok);
    rd = '0; err = 1'b0; ok = 1'b0;
    @(posedge clk); #1;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        ok = 1'b1; rd = bus.if_rdata; err = bus.bus_err;
        break;
      end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic dop(input bit we, input logic [63:0] a, input logic [63:0] wd,
                     output logic [63:0] rd, output bit err, output bit ok);
    rd = '0; err = 1'b0; ok = 1'b0;
    @(posedge clk); #1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.d_valid) begin
        ok = 1'b1; rd = bus.d_rdata; err = bus.bus_err;
        break;
      end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.d_req = 1'b1; bus.d_addr = 64'h80;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.bus_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
                      {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.bus_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 256'b0) begin
      bad++; $display("FAIL reset_data: mem_addr=%h mem_wdata=%h if_rdata=%h d_rdata=%h want 0",
                      bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    total++;
    if (bus.stall_mem !== 1'b1) begin
      bad++; $display("FAIL reset_stall_mem: got %b want 1", bus.stall_mem);
    end
    total++;
    if (bus.stall_if !== 1'b0) begin
      bad++; $display("FAIL reset_stall_if: got %b want 0", bus.stall_if);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL reset_release_idle: mem_req=%b want 0", bus.mem_req);
    end
  endtask

  task automatic test_if_fetch();
    int iv = -1; int mreq = 0; int nval = 0;
    logic [63:0] ird = '0; logic st0 = 1'b0; logic stv = 1'b1; logic sta = 1'b1;
    lat = 2; hang = 1'b0; rand_lat = 1'b0;
    @(posedge clk); #1;
    bus.if_addr = 64'h40; bus.if_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) st0 = bus.stall_if;
      if (bus.mem_req) mreq++;
      if (bus.if_valid) begin
        nval++;
        if (iv < 0) begin iv = c; ird = bus.if_rdata; stv = bus.stall_if; end
      end
      if (iv >= 0 && c == iv + 1) sta = bus.stall_if;
      @(posedge clk); #1;
      if (iv >= 0) bus.if_req = 1'b0;
    end
    total++;
    if (st0 !== 1'b1) begin bad++; $display("FAIL fetch_stall_wait: got %b want 1", st0); end
    total++;
    if (iv != 3) begin bad++; $display("FAIL fetch_latency: valid at cycle %0d want 3", iv); end
    total++;
    if (mreq != 2) begin bad++; $display("FAIL fetch_mem_req_len: got %0d want 2", mreq); end
    total++;
    if (nval != 1) begin bad++; $display("FAIL fetch_valid_pulses: got %0d want 1", nval); end
    total++;
    if (ird !== 64'h00500093) begin bad++; $display("FAIL fetch_rdata: got %h want 00500093", ird); end
    total++;
    if (stv !== 1'b0 || sta !== 1'b0) begin
      bad++; $display("FAIL fetch_stall_after: at valid %b after %b want 0 0", stv, sta);
    end
  endtask

  task automatic test_priority();
    int dv = -1; int iv = -1; int irise = -1; int ngr = 0;
    logic [63:0] drd = '0; logic [63:0] ird = '0; logic [63:0] g0 = '0; logic [63:0] g1 = '0;
    logic [63:0] val; bit prev = 1'b0;
    val = {$urandom, $urandom};
    mem[64'h100] = val;
    lat = 2; hang = 1'b0; rand_lat = 1'b0;
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_addr = 64'h100; bus.d_req = 1'b1;
    bus.if_addr = 64'h40; bus.if_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev) begin
        if (ngr == 0) g0 = bus.mem_addr;
        if (ngr == 1) begin g1 = bus.mem_addr; irise = c; end
        ngr++;
      end
      prev = bus.mem_req;
      if (bus.d_valid && dv < 0) begin dv = c; drd = bus.d_rdata; end
      if (bus.if_valid && iv < 0) begin iv = c; ird = bus.if_rdata; end
      @(posedge clk); #1;
      if (dv >= 0) bus.d_req = 1'b0;
      if (iv >= 0) bus.if_req = 1'b0;
    end
    total++;
    if (g0 !== 64'h100) begin bad++; $display("FAIL prio_first_grant: addr %h want 100", g0); end
    total++;
    if (dv != 3) begin bad++; $display("FAIL prio_d_latency: cycle %0d want 3", dv); end
    total++;
    if (drd !== val) begin bad++; $display("FAIL prio_d_rdata: got %h want %h", drd, val); end
    total++;
    if (g1 !== 64'h40) begin bad++; $display("FAIL prio_second_grant: addr %h want 40", g1); end
    total++;
    if (irise != dv + 1) begin
      bad++; $display("FAIL prio_b2b: IF mem_req at cycle %0d want %0d", irise, dv + 1);
    end
    total++;
    if (iv != dv + 3 || ird !== 64'h00500093) begin
      bad++; $display("FAIL prio_if_done: cycle %0d data %h want %0d 00500093", iv, ird, dv + 3);
    end
    total++;
    if (ngr != 2) begin bad++; $display("FAIL prio_grant_count: got %0d want 2", ngr); end
  endtask

  task automatic test_streak();
    logic [63:0] seq[$];
    logic [63:0] drd[5];
    bit dok[5];
    logic [63:0] ird; bit ierr; bit iok;
    bit done_f = 1'b0; bit prev = 1'b0; int pi = -1;
    lat = 1; hang = 1'b0; rand_lat = 1'b0;
    fork
      begin
        fork
          begin
            @(posedge clk); #1;
            bus.d_we = 1'b0; bus.d_req = 1'b1;
            for (int k = 0; k < 5; k++) begin
              bus.d_addr = 64'h2000 + 64'(8 * k);
              dok[k] = 1'b0; drd[k] = '0;
              for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus.d_valid) begin dok[k] = 1'b1; drd[k] = bus.d_rdata; break; end
              end
              @(posedge clk); #1;
            end
            bus.d_req = 1'b0;
          end
          fetch(64'h1000, ird, ierr, iok);
        join
        done_f = 1'b1;
      end
      begin
        while (!done_f) begin
          @(negedge clk);
          if (bus.mem_req && !prev) seq.push_back(bus.mem_addr);
          prev = bus.mem_req;
        end
      end
    join
    for (int k = 0; k < seq.size(); k++)
      if (pi < 0 && seq[k][13:12] == 2'd1) pi = k;
    total++;
    if (seq.size() != 6) begin bad++; $display("FAIL streak_grants: got %0d want 6", seq.size()); end
    total++;
    if (seq.size() < 1 || seq[0][13:12] != 2'd2) begin
      bad++; $display("FAIL streak_first_is_data: first grant not a data access");
    end
    total++;
    if (pi < 1 || pi > MAXS) begin
      bad++; $display("FAIL streak_if_bound: IF grant index %0d want 1..%0d", pi, MAXS);
    end
    total++;
    if (pi < 0 || pi + 1 >= seq.size() || seq[pi + 1][13:12] != 2'd2) begin
      bad++; $display("FAIL streak_data_resumes: no data grant after IF grant (index %0d)", pi);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (!dok[k] || drd[k] !== init_word(64'h2000 + 64'(8 * k))) begin
        bad++; $display("FAIL streak_load%0d: ok=%0d got %h want %h", k, dok[k], drd[k],
                        init_word(64'h2000 + 64'(8 * k)));
      end
    end
    total++;
    if (!iok || ierr || ird !== init_word(64'h1000)) begin
      bad++; $display("FAIL streak_fetch: ok=%0d err=%0d got %h want %h", iok, ierr, ird,
                      init_word(64'h1000));
    end
  endtask

  task automatic test_store_load();
    int dv = -1; int mreq = 0; bit stable = 1'b1; logic berr = 1'b1;
    logic [63:0] rd; bit err; bit ok;
    lat = 3; hang = 1'b0; rand_lat = 1'b0;
    @(posedge clk); #1;
    bus.d_we = 1'b1; bus.d_addr = 64'h200; bus.d_wdata = 64'hDEADBEEF; bus.d_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        mreq++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h200 || bus.mem_wdata !== 64'hDEADBEEF)
          stable = 1'b0;
      end
      if (bus.d_valid && dv < 0) begin dv = c; berr = bus.bus_err; end
      @(posedge clk); #1;
      if (dv >= 0) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
    end
    total++;
    if (!stable) begin bad++; $display("FAIL store_stable: mem_we/addr/wdata changed during grant"); end
    total++;
    if (mreq != 3) begin bad++; $display("FAIL store_mem_req_len: got %0d want 3", mreq); end
    total++;
    if (dv != 4 || berr !== 1'b0) begin
      bad++; $display("FAIL store_valid: cycle %0d bus_err %b want 4 0", dv, berr);
    end
    dop(1'b0, 64'h200, 64'h0, rd, err, ok);
    total++;
    if (!ok || err || rd !== 64'hDEADBEEF) begin
      bad++; $display("FAIL store_readback: ok=%0d err=%0d got %h want deadbeef", ok, err, rd);
    end
  endtask

  task automatic test_timeout();
    int dv = -1; int mreq = 0;
    logic [63:0] drd = 64'hffff; logic berr = 1'b0; logic after = 1'b1;
    mem[64'h300] = 64'h1111_2222_3333_4444;
    hang = 1'b1;
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_addr = 64'h300; bus.d_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_req) mreq++;
      if (bus.d_valid && dv < 0) begin dv = c; drd = bus.d_rdata; berr = bus.bus_err; end
      else if (dv >= 0 && c == dv + 1) after = bus.bus_err | bus.d_valid;
      @(posedge clk); #1;
      if (dv >= 0) bus.d_req = 1'b0;
    end
    hang = 1'b0;
    total++;
    if (mreq != TMO) begin bad++; $display("FAIL tmo_mem_req_len: got %0d want %0d", mreq, TMO); end
    total++;
    if (dv != TMO + 1) begin bad++; $display("FAIL tmo_valid_cycle: got %0d want %0d", dv, TMO + 1); end
    total++;
    if (berr !== 1'b1) begin bad++; $display("FAIL tmo_bus_err: got %b want 1", berr); end
    total++;
    if (drd !== 64'h0) begin bad++; $display("FAIL tmo_rdata: got %h want 0", drd); end
    total++;
    if (after !== 1'b0) begin bad++; $display("FAIL tmo_pulse_width: second cycle high %b want 0", after); end
  endtask

  task automatic test_reset_mid_grant();
    bit seen = 1'b0; int rise = -1; int iv = -1; bit prev = 1'b0;
    logic [63:0] raddr = '0; logic [63:0] ird = '0; logic r_req; logic r_val;
    hang = 1'b1; lat = 2; rand_lat = 1'b0;
    @(posedge clk); #1;
    bus.if_addr = 64'h40; bus.if_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_grant_start: mem_req never rose"); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      bad++; $display("FAIL rst_immediate: mem_req=%b if_valid=%b want 0 0", bus.mem_req, bus.if_valid);
    end
    @(posedge clk); #1;
    hang = 1'b0;
    @(negedge clk);
    r_req = bus.mem_req; r_val = bus.if_valid;
    total++;
    if (r_req !== 1'b0 || r_val !== 1'b0) begin
      bad++; $display("FAIL rst_held: mem_req=%b if_valid=%b want 0 0", r_req, r_val);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev && rise < 0) begin rise = c; raddr = bus.mem_addr; end
      prev = bus.mem_req;
      if (bus.if_valid && iv < 0) begin iv = c; ird = bus.if_rdata; end
      @(posedge clk); #1;
      if (iv >= 0) bus.if_req = 1'b0;
    end
    total++;
    if (rise != 1 || raddr !== 64'h40) begin
      bad++; $display("FAIL rst_regrant: mem_req rose at %0d addr %h want 1 40", rise, raddr);
    end
    total++;
    if (iv != 3 || ird !== 64'h00500093) begin
      bad++; $display("FAIL rst_regrant_done: valid at %0d data %h want 3 00500093", iv, ird);
    end
  endtask

  task automatic test_random();
    bit done_r = 1'b0;
    int run = 0; bit prev = 1'b0; bit prev_i = 1'b0; bit prev_d = 1'b0;
    rand_lat = 1'b1; hang = 1'b0;
    fork
      begin
        fork
          begin
            logic [63:0] a; logic [63:0] rd; bit err; bit ok;
            for (int k = 0; k < 20; k++) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              a = 64'h1000 + 64'(8 * $urandom_range(0, 31));
              fetch(a, rd, err, ok);
              total++;
              if (!ok || err || rd !== init_word(a)) begin
                bad++; $display("FAIL rnd_fetch: addr %h ok=%0d err=%0d got %h want %h",
                                a, ok, err, rd, init_word(a));
              end
            end
          end
          begin
            logic [63:0] a; logic [63:0] wd; logic [63:0] rd; logic [63:0] ex; bit we; bit err; bit ok;
            for (int k = 0; k < 20; k++) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              we = 1'($urandom_range(0, 1));
              a  = 64'h2000 + 64'(8 * $urandom_range(0, 7));
              wd = {$urandom, $urandom};
              ex = dshadow.exists(a) ? dshadow[a] : init_word(a);
              dop(we, a, wd, rd, err, ok);
              if (we && ok) dshadow[a] = wd;
              total++;
              if (!ok || err || (!we && rd !== ex)) begin
                bad++; $display("FAIL rnd_data: we=%0d addr %h ok=%0d err=%0d got %h want %h",
                                we, a, ok, err, rd, ex);
              end
            end
          end
        join
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          @(negedge clk);
          if (bus.mem_req && !prev) begin
            total++;
            if (bus.mem_addr[13:12] == 2'd2) begin
              run = prev_i ? run + 1 : 0;
              if (run > MAXS) begin
                bad++; $display("FAIL rnd_streak: %0d data grants while IF waits, max %0d", run, MAXS);
              end
            end else begin
              if (prev_d && run != MAXS) begin
                bad++; $display("FAIL rnd_priority: IF granted over data with streak %0d want %0d",
                                run, MAXS);
              end
              run = 0;
            end
          end
          prev   = bus.mem_req;
          prev_i = bus.if_req && !bus.if_valid;
          prev_d = bus.d_req && !bus.d_valid;
        end
      end
    join
    rand_lat = 1'b0;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mem[64'h40] = 64'h00500093;
    reset = 1'b0;
    test_reset();
    test_if_fetch();
    test_priority();
    test_streak();
    test_store_load();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
